// File: rtl/uoram_return_packer.sv
// uoram_return_packer
//
// Store-and-forward return stage. Collects one block of FEDWidth-bit return
// chunks, then sends a tag header word followed by the block contents to the
// network in NetWidth-bit words. The contents go out chunk 0 first, and the low
// slice of each chunk goes first. Blocks flagged as dummy reads are absorbed
// and never reach the network. Only one block is in flight at a time.
//
// Ports
//    Clock, Reset           : single clock, asynchronous active-high reset
//    BlockStartReady (out)  : packer can take a block descriptor
//    BlockStart/Tag/Discard : descriptor valid, header word, drop-block flag
//    InReady (out)          : chunk-stream ready
//    InValid/InData         : chunk valid, chunk data
//    NetReady               : network accepts a word
//    NetValid/NetData (out) : network word valid, network word
//    BlockDone (out)        : one-cycle pulse the cycle after a block finishes
//
// state   | meaning
// --------+-------------------------------------------------------------
// StIdle  | waiting for a block descriptor
// StFill  | accepting chunks into the buffer (dropped if Discard latched)
// StHdr   | presenting the latched tag as the header word
// StDrain | presenting buffered words, low slice of chunk 0 first

module uoram_return_packer #(
   parameter int FEDWidth    = 64,
   parameter int NetWidth    = 32,
   parameter int BlockChunks = 4
) (
   input  logic                Clock,
   input  logic                Reset,
   output logic                BlockStartReady,
   input  logic                BlockStart,
   input  logic [NetWidth-1:0] Tag,
   input  logic                Discard,
   output logic                InReady,
   input  logic                InValid,
   input  logic [FEDWidth-1:0] InData,
   input  logic                NetReady,
   output logic                NetValid,
   output logic [NetWidth-1:0] NetData,
   output logic                BlockDone
);

   localparam int R          = FEDWidth / NetWidth;
   localparam int BlockWords = BlockChunks * R;
   localparam int ChunkCntW  = $clog2(BlockChunks) + 1;
   localparam int WordCntW   = $clog2(BlockWords) + 1;
   localparam int ChunkIdxW  = (BlockChunks > 1) ? $clog2(BlockChunks) : 1;
   localparam int WordIdxW   = (BlockWords > 1) ? $clog2(BlockWords) : 1;
   localparam logic [ChunkCntW-1:0] LastChunk = ChunkCntW'(BlockChunks - 1);
   localparam logic [WordCntW-1:0]  LastWord  = WordCntW'(BlockWords - 1);

   typedef enum logic [1:0] {StIdle, StFill, StHdr, StDrain} stateType;

   stateType             state, nextState;
   logic [ChunkCntW-1:0] chunkCnt;
   logic [WordCntW-1:0]  wordCnt;
   logic [NetWidth-1:0]  tagReg;
   logic                 discardReg;
   logic                 blockDoneReg;

   // Block storage is deliberately not reset; it is always fully rewritten
   // before being read out.
   logic [FEDWidth-1:0]  blockBuf [BlockChunks];
   logic [NetWidth-1:0]  wordView [BlockWords];

   logic inHs, drainHs, lastChunkHs, lastWordHs;

   assign inHs        = (state == StFill) && InValid;
   assign drainHs     = (state == StDrain) && NetReady;
   assign lastChunkHs = inHs && (chunkCnt == LastChunk);
   assign lastWordHs  = drainHs && (wordCnt == LastWord);

   always_comb begin
      nextState = state;
      case (state)
         StIdle:  if (BlockStart)  nextState = StFill;
         StFill:  if (lastChunkHs) nextState = discardReg ? StIdle : StHdr;
         StHdr:   if (NetReady)    nextState = StDrain;
         StDrain: if (lastWordHs)  nextState = StIdle;
         default:                  nextState = StIdle;
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state        <= StIdle;
         chunkCnt     <= '0;
         wordCnt      <= '0;
         tagReg       <= '0;
         discardReg   <= 1'b0;
         blockDoneReg <= 1'b0;
      end else begin
         state        <= nextState;
         blockDoneReg <= (lastChunkHs && discardReg) || lastWordHs;
         if ((state == StIdle) && BlockStart) begin
            tagReg     <= Tag;
            discardReg <= Discard;
         end
         // Clearing on every entry to idle also leaves wordCnt at 0 for the
         // next drain, since the drain always follows idle via fill and header.
         if (nextState == StIdle) begin
            chunkCnt <= '0;
            wordCnt  <= '0;
         end else begin
            if (inHs)    chunkCnt <= chunkCnt + 1'b1;
            if (drainHs) wordCnt  <= wordCnt + 1'b1;
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (inHs && !discardReg)
         blockBuf[chunkCnt[ChunkIdxW-1:0]] <= InData;
   end

   // Flattened view of the buffer in transmit order: word c*R+s is slice s of chunk c.
   always_comb begin
      for (int c = 0; c < BlockChunks; c++)
         for (int s = 0; s < R; s++)
            wordView[c*R + s] = blockBuf[c][s*NetWidth +: NetWidth];
   end

   assign BlockStartReady = (state == StIdle);
   assign InReady         = (state == StFill);
   assign NetValid        = (state == StHdr) || (state == StDrain);
   assign NetData         = (state == StHdr) ? tagReg : wordView[wordCnt[WordIdxW-1:0]];
   assign BlockDone       = blockDoneReg;

endmodule
